// File: rtl/uart_com.sv
// rtl/uart_com.sv - 8N1 full-duplex UART with independent TX and RX state machines
module uart_com #(
  parameter int INPUT_CLK_KHZ = 100_000,
  parameter int BAUD_RATE     = 115200
) (
  input  logic       input_clk,
  input  logic       reset_n,
  input  logic       trans_en,
  input  logic [7:0] data_out,
  input  logic       Rx,
  output logic       Tx,
  output logic       tx_busy,
  output logic       data_rdy,
  output logic [7:0] data_received
);

  localparam int BIT_CLKS = (INPUT_CLK_KHZ * 1000) / BAUD_RATE;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d, tx_bit_nxt;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q, tx_busy_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_data_d  = tx_data_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    tx_bit_nxt = tx_bit_q + 3'd1;
    case (tx_state_q)
      ST_IDLE: begin
        if (trans_en) begin
          tx_state_d = ST_START;
          tx_data_d  = data_out;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_data_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_nxt;
            tx_line_d = tx_data_q[tx_bit_nxt];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_IDLE;
          tx_cnt_d   = '0;
          tx_line_d  = 1'b1;
          tx_busy_d  = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  // Tx is a registered output, so the async reset drives it high immediately.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_data_q  <= 8'h00;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_data_q  <= tx_data_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_err_q, rx_err_d;
  logic             rdy_q, rdy_d;
  logic [7:0]       rx_data_q, rx_data_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_err_d   = rx_err_q;
    rx_data_d  = rx_data_q;
    rdy_d      = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
            rx_err_d   = 1'b0;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        // After a framing error stay here until the line returns high.
        if (rx_err_q) begin
          if (rx_s2_q) begin
            rx_state_d = ST_IDLE;
            rx_err_d   = 1'b0;
          end
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            rx_state_d = ST_IDLE;
            rx_data_d  = rx_shift_q;
            rdy_d      = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_err_q   <= 1'b0;
      rdy_q      <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_s1_q    <= Rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_err_q   <= rx_err_d;
      rdy_q      <= rdy_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign Tx            = tx_line_q;
  assign tx_busy       = tx_busy_q;
  assign data_rdy      = rdy_q;
  assign data_received = rx_data_q;

endmodule

// File: tb/tb_uart_com.sv
// tb/tb_uart_com.sv - directed self-checking bench for uart_com
module tb_uart_com;

  localparam int BIT  = 868;
  localparam int HALF = 434;

  logic       input_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       trans_en  = 1'b0;
  logic [7:0] data_out  = 8'h00;
  logic       rx_drv    = 1'b1;
  logic       loop_en   = 1'b0;
  logic       rx_line;
  logic       Tx, tx_busy, data_rdy;
  logic [7:0] data_received;

  int checks   = 0;
  int failures = 0;
  int rdy_cnt  = 0;
  int base;

  assign rx_line = loop_en ? Tx : rx_drv;

  uart_com dut (
    .input_clk    (input_clk),
    .reset_n      (reset_n),
    .trans_en     (trans_en),
    .data_out     (data_out),
    .Rx           (rx_line),
    .Tx           (Tx),
    .tx_busy      (tx_busy),
    .data_rdy     (data_rdy),
    .data_received(data_received)
  );

  always #5 input_clk = ~input_clk;

  // Counts clocks with data_rdy high, so one frame must add exactly one.
  always @(negedge input_clk) if (data_rdy === 1'b1) rdy_cnt = rdy_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge input_clk);
    #1;
  endtask

  task automatic tx_frame(input string tag, input logic [7:0] b, input logic inject, input logic [7:0] b2);
    logic [9:0] exp_bits;
    int off;
    int target;
    logic injected;
    exp_bits = {1'b1, b, 1'b0};
    injected = 1'b0;
    data_out = b;
    trans_en = 1'b1;
    cyc(1);
    trans_en = 1'b0;
    check({tag, " busy_start"}, 32'(tx_busy), 32'(1));
    off = 0;
    for (int i = 0; i < 10; i++) begin
      target = HALF + BIT * i;
      if (inject && !injected && target > 1000) begin
        cyc(1000 - off);
        data_out = b2;
        trans_en = 1'b1;
        cyc(1);
        trans_en = 1'b0;
        off = 1001;
        injected = 1'b1;
      end
      cyc(target - off);
      off = target;
      check($sformatf("%s bit%0d", tag, i), 32'(Tx), 32'(exp_bits[i]));
    end
    cyc(BIT * 10 - 1 - off);
    check({tag, " busy_last"}, 32'(tx_busy), 32'(1));
    cyc(1);
    check({tag, " busy_end"}, 32'(tx_busy), 32'(0));
    check({tag, " tx_idle"}, 32'(Tx), 32'(1));
  endtask

  task automatic rx_bits(input logic [7:0] b);
    rx_drv = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(BIT);
    end
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    rx_bits(b);
    rx_drv = stop;
    cyc(BIT);
    rx_drv = 1'b1;
  endtask

  initial begin
    cyc(3);
    check("rst_tx", 32'(Tx), 32'(1));
    check("rst_busy", 32'(tx_busy), 32'(0));
    check("rst_rdy", 32'(data_rdy), 32'(0));
    check("rst_data", 32'(data_received), 32'(8'h00));
    reset_n = 1'b1;
    cyc(2);

    tx_frame("tx_a5", 8'hA5, 1'b0, 8'h00);
    cyc(5);

    base = rdy_cnt;
    rx_bits(8'h3C);
    rx_drv = 1'b1;
    cyc(430);
    check("rx3c_early", 32'(rdy_cnt), 32'(base));
    cyc(20);
    check("rx3c_pulse", 32'(rdy_cnt), 32'(base + 1));
    check("rx3c_data", 32'(data_received), 32'(8'h3C));
    cyc(BIT);
    check("rx3c_single", 32'(rdy_cnt), 32'(base + 1));

    base = rdy_cnt;
    rx_drv = 1'b0;
    cyc(100);
    rx_drv = 1'b1;
    cyc(700);
    check("glitch_nordy", 32'(rdy_cnt), 32'(base));
    rx_frame(8'h55, 1'b1);
    cyc(10);
    check("rx55_pulse", 32'(rdy_cnt), 32'(base + 1));
    check("rx55_data", 32'(data_received), 32'(8'h55));

    base = rdy_cnt;
    rx_frame(8'hFF, 1'b0);
    cyc(BIT);
    check("ferr_nordy", 32'(rdy_cnt), 32'(base));
    check("ferr_keep", 32'(data_received), 32'(8'h55));
    rx_frame(8'hA0, 1'b1);
    cyc(10);
    check("ferr_recover_pulse", 32'(rdy_cnt), 32'(base + 1));
    check("ferr_recover_data", 32'(data_received), 32'(8'hA0));

    tx_frame("busy_11", 8'h11, 1'b1, 8'h22);
    cyc(20);
    check("busy_no_second", 32'(tx_busy), 32'(0));
    check("busy_tx_idle", 32'(Tx), 32'(1));

    data_out = 8'h00;
    trans_en = 1'b1;
    cyc(1);
    trans_en = 1'b0;
    rx_drv = 1'b0;
    cyc(2000);
    check("pre_rst_tx", 32'(Tx), 32'(0));
    check("pre_rst_busy", 32'(tx_busy), 32'(1));
    @(posedge input_clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_tx", 32'(Tx), 32'(1));
    check("arst_busy", 32'(tx_busy), 32'(0));
    check("arst_rdy", 32'(data_rdy), 32'(0));
    check("arst_data", 32'(data_received), 32'(8'h00));
    cyc(5);
    rx_drv = 1'b1;
    reset_n = 1'b1;
    cyc(5);

    loop_en = 1'b1;
    base = rdy_cnt;
    data_out = 8'h81;
    trans_en = 1'b1;
    cyc(1);
    trans_en = 1'b0;
    cyc(BIT * 10 + 20);
    check("loop_pulse", 32'(rdy_cnt), 32'(base + 1));
    check("loop_data", 32'(data_received), 32'(8'h81));
    check("loop_busy", 32'(tx_busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
